// File: rtl/meas_seq_pkg.sv
// Shared definitions for the measurement sequencer.
//   state_e          : 10-state FSM encoding, 4 bits
//   DEF_GATE_CYCLES  : default gate window length (100 ms at 100 MHz)
//   DEF_CONV_TIMEOUT : default converter wait limit in cycles
//   SEL_FREQ/SEL_PEAK: conv_sel encodings
package meas_seq_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_CLEAN  = 4'd1,
      S_GATE   = 4'd2,
      S_LATCH  = 4'd3,
      S_CONV_F = 4'd4,
      S_WAIT_F = 4'd5,
      S_CONV_P = 4'd6,
      S_WAIT_P = 4'd7,
      S_LOAD   = 4'd8,
      S_REPORT = 4'd9
   } state_e;

   localparam int unsigned DEF_GATE_CYCLES  = 10_000_000;
   localparam int unsigned DEF_CONV_TIMEOUT = 64;

   localparam logic SEL_FREQ = 1'b1;
   localparam logic SEL_PEAK = 1'b0;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter with a zero flag.
//   clk, rst : clock, asynchronous active-high reset
//   load_i   : load LOAD_VAL (takes priority over dec_i)
//   dec_i    : decrement by one, saturating at zero
//   zero_o   : counter currently reads zero
module seq_timer #(
   parameter int unsigned LOAD_VAL = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam int W = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = W'(LOAD_VAL);
      else if (dec_i && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/meas_sequencer.sv
// Measurement-cycle scheduler: clear, gate, latch, two shared conversions,
// display load and UART report, repeated while enable is high.
//   clk, rst              : clock, asynchronous active-high reset
//   enable                : run cycles (sampled in IDLE and at REPORT exit)
//   clean/gate/latch      : accumulator clear, count window, raw capture
//   conv_start/conv_sel   : shared converter start pulse and input select
//   conv_done             : converter result valid
//   disp_load             : load both BCD results into the display
//   tx_req/tx_ack         : report handshake
//   busy/cycle_cnt/err    : status, completed cycles, sticky timeout flag
module meas_sequencer
   import meas_seq_pkg::*;
#(
   parameter int unsigned GATE_CYCLES  = DEF_GATE_CYCLES,
   parameter int unsigned CONV_TIMEOUT = DEF_CONV_TIMEOUT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   output logic       clean,
   output logic       gate,
   output logic       latch,
   output logic       conv_start,
   output logic       conv_sel,
   input  logic       conv_done,
   output logic       disp_load,
   output logic       tx_req,
   input  logic       tx_ack,
   output logic       busy,
   output logic [7:0] cycle_cnt,
   output logic       err
);

   state_e     state_q, state_d;
   logic       gate_load, gate_dec, gate_zero;
   logic       to_load, to_dec, to_zero;
   logic       err_set, cnt_inc;
   logic       clean_q, gate_q, latch_q, start_q, sel_q, load_q, req_q, busy_q, err_q;
   logic       sel_d;
   logic [7:0] cnt_q;

   seq_timer #(.LOAD_VAL(GATE_CYCLES - 1)) u_gate_tmr (
      .clk(clk), .rst(rst), .load_i(gate_load), .dec_i(gate_dec), .zero_o(gate_zero)
   );

   seq_timer #(.LOAD_VAL(CONV_TIMEOUT - 1)) u_conv_tmr (
      .clk(clk), .rst(rst), .load_i(to_load), .dec_i(to_dec), .zero_o(to_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      gate_load = 1'b0;
      gate_dec  = 1'b0;
      to_load   = 1'b0;
      to_dec    = 1'b0;
      err_set   = 1'b0;
      cnt_inc   = 1'b0;
      case (state_q)
         S_IDLE:   if (enable) state_d = S_CLEAN;
         S_CLEAN:  begin gate_load = 1'b1; state_d = S_GATE; end
         S_GATE:   begin
                      gate_dec = 1'b1;
                      if (gate_zero) state_d = S_LATCH;
                   end
         S_LATCH:  state_d = S_CONV_F;
         S_CONV_F: begin to_load = 1'b1; state_d = S_WAIT_F; end
         S_WAIT_F: begin
                      to_dec = 1'b1;
                      // a late result on the last cycle still counts as done
                      if (conv_done)    state_d = S_CONV_P;
                      else if (to_zero) begin err_set = 1'b1; state_d = S_CONV_P; end
                   end
         S_CONV_P: begin to_load = 1'b1; state_d = S_WAIT_P; end
         S_WAIT_P: begin
                      to_dec = 1'b1;
                      if (conv_done)    state_d = S_LOAD;
                      else if (to_zero) begin err_set = 1'b1; state_d = S_LOAD; end
                   end
         S_LOAD:   state_d = S_REPORT;
         S_REPORT: if (tx_ack) begin
                      cnt_inc = 1'b1;
                      state_d = enable ? S_CLEAN : S_IDLE;
                   end
         default:  state_d = S_IDLE;
      endcase
   end

   // conv_sel tracks the conversion in progress and otherwise holds
   always_comb begin
      sel_d = sel_q;
      if (state_d == S_CONV_F || state_d == S_WAIT_F)      sel_d = SEL_FREQ;
      else if (state_d == S_CONV_P || state_d == S_WAIT_P) sel_d = SEL_PEAK;
   end

   // Outputs registered from the next state so each one is a clean decode
   // of the state register, valid for exactly the cycles spent in that state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clean_q <= 1'b0;
         gate_q  <= 1'b0;
         latch_q <= 1'b0;
         start_q <= 1'b0;
         sel_q   <= SEL_PEAK;
         load_q  <= 1'b0;
         req_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         clean_q <= (state_d == S_CLEAN);
         gate_q  <= (state_d == S_GATE);
         latch_q <= (state_d == S_LATCH);
         start_q <= (state_d == S_CONV_F) || (state_d == S_CONV_P);
         sel_q   <= sel_d;
         load_q  <= (state_d == S_LOAD);
         req_q   <= (state_d == S_REPORT);
         busy_q  <= (state_d != S_IDLE);
         err_q   <= err_q | err_set;
         if (cnt_inc) cnt_q <= cnt_q + 8'd1;
      end
   end

   assign clean      = clean_q;
   assign gate       = gate_q;
   assign latch      = latch_q;
   assign conv_start = start_q;
   assign conv_sel   = sel_q;
   assign disp_load  = load_q;
   assign tx_req     = req_q;
   assign busy       = busy_q;
   assign err        = err_q;
   assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_meas_sequencer.sv
module tb_meas_sequencer;

   localparam int G = 16;
   localparam int T = 8;

   // phases of a measurement cycle as the reference model sees them
   localparam int P_IDLE = 0, P_CLEAN = 1, P_GATE = 2, P_LATCH = 3, P_CONVF = 4,
                  P_WAITF = 5, P_CONVP = 6, P_WAITP = 7, P_LOAD = 8, P_REPORT = 9;

   logic       clk, rst, enable, conv_done, tx_ack;
   logic       clean, gate, latch, conv_start, conv_sel, disp_load, tx_req, busy, err;
   logic [7:0] cycle_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model
   int         ph, el;
   logic [7:0] m_cnt;
   logic       m_err, m_sel;

   meas_sequencer #(.GATE_CYCLES(G), .CONV_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .clean(clean), .gate(gate), .latch(latch),
      .conv_start(conv_start), .conv_sel(conv_sel), .conv_done(conv_done),
      .disp_load(disp_load), .tx_req(tx_req), .tx_ack(tx_ack),
      .busy(busy), .cycle_cnt(cycle_cnt), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      ph = P_IDLE; el = 0; m_cnt = 8'd0; m_err = 1'b0; m_sel = 1'b0;
   endtask

   // One clock edge of the reference behaviour, given the inputs seen at that edge.
   // Waits are measured as elapsed cycles against their limits.
   task automatic m_step(input logic en, input logic done, input logic ack);
      case (ph)
         P_IDLE:   if (en) ph = P_CLEAN;
         P_CLEAN:  begin ph = P_GATE; el = 0; end
         P_GATE:   begin el++; if (el == G) ph = P_LATCH; end
         P_LATCH:  ph = P_CONVF;
         P_CONVF:  begin ph = P_WAITF; el = 0; end
         P_WAITF:  begin
                      el++;
                      if (done) ph = P_CONVP;
                      else if (el == T) begin m_err = 1'b1; ph = P_CONVP; end
                   end
         P_CONVP:  begin ph = P_WAITP; el = 0; end
         P_WAITP:  begin
                      el++;
                      if (done) ph = P_LOAD;
                      else if (el == T) begin m_err = 1'b1; ph = P_LOAD; end
                   end
         P_LOAD:   ph = P_REPORT;
         P_REPORT: if (ack) begin m_cnt = m_cnt + 8'd1; ph = en ? P_CLEAN : P_IDLE; end
         default:  ph = P_IDLE;
      endcase
      if (ph == P_CONVF || ph == P_WAITF) m_sel = 1'b1;
      if (ph == P_CONVP || ph == P_WAITP) m_sel = 1'b0;
   endtask

   task automatic compare_all();
      chk("clean",      32'(clean),      32'(ph == P_CLEAN));
      chk("gate",       32'(gate),       32'(ph == P_GATE));
      chk("latch",      32'(latch),      32'(ph == P_LATCH));
      chk("conv_start", 32'(conv_start), 32'(ph == P_CONVF || ph == P_CONVP));
      chk("conv_sel",   32'(conv_sel),   32'(m_sel));
      chk("disp_load",  32'(disp_load),  32'(ph == P_LOAD));
      chk("tx_req",     32'(tx_req),     32'(ph == P_REPORT));
      chk("busy",       32'(busy),       32'(ph != P_IDLE));
      chk("cycle_cnt",  32'(cycle_cnt),  32'(m_cnt));
      chk("err",        32'(err),        32'(m_err));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_clean"}, 32'(clean), 32'd0);
      chk({tag, "_gate"},  32'(gate),  32'd0);
      chk({tag, "_latch"}, 32'(latch), 32'd0);
      chk({tag, "_start"}, 32'(conv_start), 32'd0);
      chk({tag, "_sel"},   32'(conv_sel),   32'd0);
      chk({tag, "_load"},  32'(disp_load),  32'd0);
      chk({tag, "_req"},   32'(tx_req),     32'd0);
      chk({tag, "_busy"},  32'(busy),       32'd0);
      chk({tag, "_cnt"},   32'(cycle_cnt),  32'd0);
      chk({tag, "_err"},   32'(err),        32'd0);
   endtask

   // advance one cycle: model sees the same inputs as the DUT edge, compare just after
   task automatic tick();
      @(posedge clk);
      if (rst) m_reset();
      else     m_step(enable, conv_done, tx_ack);
      #1;
      compare_all();
   endtask

   initial begin
      int         gcnt, s1, s2, e1, dl, req_n, ok, found, idle, post;
      logic [7:0] snap, prev;
      logic       wrapped;

      rst = 1'b1; enable = 1'b0; conv_done = 1'b0; tx_ack = 1'b0;
      m_reset();
      #1;
      chk_all_zero("reset");
      tick(); tick();
      rst = 1'b0;
      repeat (3) tick();

      // A: everything answers immediately, continuous run
      conv_done = 1'b1; tx_ack = 1'b1; enable = 1'b1;
      gcnt = 0;
      for (int i = 1; i <= 73; i++) begin
         tick();
         if (i <= 24 && gate) gcnt++;
         if (i == 1)  chk("A_clean_first", 32'(clean), 32'd1);
         if (i == 2)  chk("A_gate_rise",   32'(gate),  32'd1);
         if (i == 17) chk("A_gate_last",   32'(gate),  32'd1);
         if (i == 18) chk("A_latch",       32'(latch), 32'd1);
         if (i == 19) chk("A_conv_start",  32'(conv_start), 32'd1);
         if (i == 24) chk("A_report",      32'(tx_req), 32'd1);
         if (i == 25) chk("A_period",      32'(clean), 32'd1);
         if (i == 72) chk("A_cnt_72",      32'(cycle_cnt), 32'd2);
         if (i == 73) chk("A_cnt_73",      32'(cycle_cnt), 32'd3);
      end
      chk("A_gate_len", 32'(gcnt), 32'd16);

      // B: converter never answers, both waits time out
      conv_done = 1'b0;
      s1 = -1; s2 = -1; e1 = -1; dl = -1;
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (conv_start) begin
            if (s1 < 0) s1 = i;
            else if (s2 < 0) s2 = i;
         end
         if (err && e1 < 0) e1 = i;
         if (disp_load) begin dl = i; break; end
      end
      chk("B_load_seen",  32'(dl >= 0), 32'd1);
      chk("B_waitf_len",  32'(s2 - s1), 32'd9);
      chk("B_err_rise",   32'(e1),      32'(s2));
      chk("B_waitp_len",  32'(dl - s2), 32'd9);

      // C: UART acknowledges late
      tx_ack = 1'b0; conv_done = 1'b1;
      snap = m_cnt; req_n = 0; ok = 0;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (tx_req) req_n++;
         if (req_n == 6) begin tx_ack = 1'b1; ok = 1; break; end
      end
      chk("C_req_seen", 32'(ok), 32'd1);
      tick();
      chk("C_req_drop", 32'(tx_req), 32'd0);
      chk("C_clean",    32'(clean),  32'd1);
      chk("C_cnt",      32'(cycle_cnt), 32'(snap + 8'd1));

      // D: enable dropped during the gate window
      found = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (gate) begin found = 1; break; end
      end
      chk("D_gate_seen", 32'(found), 32'd1);
      enable = 1'b0;
      snap = m_cnt; idle = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!busy) begin idle = 1; break; end
      end
      chk("D_idle", 32'(idle), 32'd1);
      chk("D_cnt",  32'(cycle_cnt), 32'(snap + 8'd1));
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("D_gate_low", 32'(gate), 32'd0);
         chk("D_busy_low", 32'(busy), 32'd0);
      end

      // E: reset while waiting for the frequency conversion
      enable = 1'b1; conv_done = 1'b0; found = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (conv_start && conv_sel) begin found = 1; break; end
      end
      chk("E_convf_seen", 32'(found), 32'd1);
      tick();
      #3 rst = 1'b1;
      #1 chk_all_zero("E_async");
      m_reset();
      tick(); tick();
      rst = 1'b0; conv_done = 1'b1;
      tick();
      chk("E_restart", 32'(clean), 32'd1);

      // R: randomized traffic until the cycle counter wraps
      wrapped = 1'b0; prev = cycle_cnt; post = 0;
      for (int i = 0; i < 25000 && post < 60; i++) begin
         enable    = ($urandom % 16) != 0;
         conv_done = ($urandom % 3) == 0;
         tx_ack    = ($urandom % 2) == 1;
         tick();
         if (prev == 8'd255 && cycle_cnt == 8'd0) wrapped = 1'b1;
         prev = cycle_cnt;
         if (wrapped) post++;
      end
      chk("R_wrap_seen", 32'(wrapped), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
